// File: rtl/dsm_cic_decimator.sv
// CIC decimator for the delta-sigma bitstream: maps 1/0 to +1/-1, integrates at the
// bit rate, combs at the decimated rate and emits saturated signed PCM words.
module dsm_cic_decimator #(
  parameter int DATA_WIDTH = 16,
  parameter int CIC_ORDER  = 3,
  parameter int LOG2_RATIO = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_quantized_bit,
  input  logic                  i_bit_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_clip
);

  localparam int ACC_WIDTH = CIC_ORDER * LOG2_RATIO + 2;
  localparam int SHIFT     = CIC_ORDER * LOG2_RATIO - (DATA_WIDTH - 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

  if (SHIFT < 0) begin : g_bad_shift
    $error("dsm_cic_decimator: CIC_ORDER*LOG2_RATIO must be >= DATA_WIDTH-1");
  end
  if (CIC_ORDER < 1 || CIC_ORDER > 5) begin : g_bad_order
    $error("dsm_cic_decimator: CIC_ORDER must be in 1..5");
  end

  // Input side has no back-pressure: every cycle with i_bit_valid high consumes
  // exactly one bit; output side is a push-only o_valid pulse with no ready.
  logic signed [ACC_WIDTH-1:0] x_in;
  logic signed [ACC_WIDTH-1:0] integ    [CIC_ORDER];
  logic signed [ACC_WIDTH-1:0] comb_dly [CIC_ORDER];
  logic signed [ACC_WIDTH-1:0] comb_val [CIC_ORDER+1];
  logic signed [ACC_WIDTH-1:0] dec_sample;
  logic signed [ACC_WIDTH-1:0] shifted;
  logic        [LOG2_RATIO-1:0] sample_cnt;
  logic                         dec_strobe;
  logic        [DATA_WIDTH-1:0] sat_word;
  logic                         sat_hit;

  assign x_in = i_quantized_bit ? ACC_WIDTH'(1) : '1;

  // Integrators and decimation counter; wrap in ACC_WIDTH is harmless because
  // the combs undo it modulo 2**ACC_WIDTH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < CIC_ORDER; k++) integ[k] <= '0;
      sample_cnt <= '0;
      dec_sample <= '0;
      dec_strobe <= 1'b0;
    end else begin
      dec_strobe <= 1'b0;
      if (i_bit_valid) begin
        integ[0] <= integ[0] + x_in;
        for (int k = 1; k < CIC_ORDER; k++) integ[k] <= integ[k] + integ[k-1];
        sample_cnt <= sample_cnt + 1'b1;
        if (&sample_cnt) begin
          dec_sample <= integ[CIC_ORDER-1];
          dec_strobe <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    comb_val[0] = dec_sample;
    for (int k = 0; k < CIC_ORDER; k++) comb_val[k+1] = comb_val[k] - comb_dly[k];
    shifted  = comb_val[CIC_ORDER] >>> SHIFT;
    sat_hit  = 1'b0;
    sat_word = shifted[DATA_WIDTH-1:0];
    if (shifted > OUT_MAX) begin
      sat_word = OUT_MAX[DATA_WIDTH-1:0];
      sat_hit  = 1'b1;
    end else if (shifted < OUT_MIN) begin
      sat_word = OUT_MIN[DATA_WIDTH-1:0];
      sat_hit  = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < CIC_ORDER; k++) comb_dly[k] <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_clip  <= 1'b0;
    end else begin
      o_valid <= dec_strobe;
      if (dec_strobe) begin
        for (int k = 0; k < CIC_ORDER; k++) comb_dly[k] <= comb_val[k];
        o_data <= sat_word;
        o_clip <= sat_hit;
      end
    end
  end

endmodule

// File: tb/tb_dsm_cic_decimator.sv
// Directed bench for dsm_cic_decimator: constant and periodic bit patterns with and
// without valid gaps, integrator wrap, mid-frame reset; expected words hand-computed.
module tb_dsm_cic_decimator;

  localparam int DW    = 16;
  localparam int RATIO = 64;
  localparam int FILL  = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_quantized_bit = 1'b0;
  logic          i_bit_valid = 1'b0;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_clip;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW:0] exp_q[$];
  logic [DW:0] obs_q[$];

  // Expected {clip, data} words for the settled outputs
  localparam logic [DW:0] W_POS_FS = {1'b1, 16'h7fff};
  localparam logic [DW:0] W_NEG_FS = {1'b0, 16'h8000};
  localparam logic [DW:0] W_ZERO   = {1'b0, 16'h0000};
  localparam logic [DW:0] W_HALF   = {1'b0, 16'h4000};

  dsm_cic_decimator dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_quantized_bit (i_quantized_bit),
    .i_bit_valid     (i_bit_valid),
    .o_data          (o_data),
    .o_valid         (o_valid),
    .o_clip          (o_clip)
  );

  // ---------------- clock ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- output timing model ----------------
  // exp_pipe[1] is where o_valid must be high: one edge after the edge that
  // consumed the 64th bit of a frame.
  int         acc_cnt;
  logic [1:0] exp_pipe;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_cnt  = 0;
      exp_pipe = 2'b00;
    end else begin
      exp_pipe = {exp_pipe[0], (i_bit_valid && (acc_cnt % RATIO == RATIO - 1))};
      if (i_bit_valid) acc_cnt++;
    end
  end

  always @(negedge i_clk) begin
    if (i_rst_n && (o_valid || exp_pipe[1])) begin
      check_eq("valid_timing", {31'd0, o_valid}, {31'd0, exp_pipe[1]});
      if (o_valid) obs_q.push_back({o_clip, o_data});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n     = 1'b0;
    i_bit_valid = 1'b0;
    #1;
    check_eq("rst_data",  {16'd0, o_data}, 32'd0);
    check_eq("rst_valid", {31'd0, o_valid}, 32'd0);
    check_eq("rst_clip",  {31'd0, o_clip}, 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    obs_q.delete();
    exp_q.delete();
  endtask

  // Feeds n_acc accepted bits; pattern[k%4] is the k-th accepted bit.
  task automatic send_bits(input logic [3:0] pattern, input int n_acc, input int gap_pct);
    int k;
    k = 0;
    while (k < n_acc) begin
      @(negedge i_clk);
      if ($urandom_range(99) < gap_pct) begin
        i_bit_valid     = 1'b0;
        i_quantized_bit = 1'($urandom_range(1));
      end else begin
        i_bit_valid     = 1'b1;
        i_quantized_bit = pattern[k % 4];
        k++;
      end
    end
    @(negedge i_clk);
    i_bit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    i_bit_valid = 1'b0;
    repeat (n) @(negedge i_clk);
  endtask

  task automatic run_case(input string tag, input logic [3:0] pattern, input int frames,
                          input int gap_pct, input logic [DW:0] exp_word);
    logic [DW:0] got;
    do_reset();
    for (int i = FILL; i < frames; i++) exp_q.push_back(exp_word);
    send_bits(pattern, frames * RATIO, gap_pct);
    idle(4);
    check_eq({tag, "_count"}, obs_q.size(), frames);
    for (int i = 0; i < FILL && obs_q.size() > 0; i++) void'(obs_q.pop_front());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      got = obs_q.pop_front();
      check_eq(tag, {15'd0, got}, {15'd0, exp_q.pop_front()});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();

    run_case("pos_fs",     4'b1111, 8, 0, W_POS_FS);
    run_case("neg_fs",     4'b0000, 8, 0, W_NEG_FS);
    run_case("alt_10",     4'b0101, 8, 0, W_ZERO);
    run_case("p1110",      4'b0111, 8, 0, W_HALF);
    run_case("alt_10_gap", 4'b0101, 8, 50, W_ZERO);
    run_case("p1110_gap",  4'b0111, 8, 50, W_HALF);
    run_case("wrap_1110",  4'b0111, 200, 0, W_HALF);

    // Mid-frame reset: settle, stop 30 bits into a frame, reset, restart counting
    do_reset();
    send_bits(4'b0111, 6 * RATIO, 0);
    idle(4);
    check_eq("mid_pre_data", {16'd0, o_data}, 32'h4000);
    send_bits(4'b0111, 30, 0);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check_eq("mid_rst_data",  {16'd0, o_data}, 32'd0);
    check_eq("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    check_eq("mid_rst_clip",  {31'd0, o_clip}, 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    obs_q.delete();
    send_bits(4'b0111, RATIO - 1, 30);
    idle(4);
    check_eq("mid_no_early", obs_q.size(), 0);
    send_bits(4'b0111, 1, 0);
    idle(4);
    check_eq("mid_first_out", obs_q.size(), 1);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
